// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select codes,
// halt-drain FSM states and the scoreboard entry field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } hz_state_e;

  // Entry payload is {wr, rd, load}, load at bit 0; the valid bit is held separately.
  localparam int SB_LOAD   = 0;
  localparam int SB_RD_LSB = 1;

  function automatic int sb_wr_bit(input int nreg_w);
    return nreg_w + 1;
  endfunction

  function automatic int sb_dat_w(input int nreg_w);
    return nreg_w + 2;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
// In-flight destination scoreboard: a DEPTH-entry shift register (EX .. WB)
// and per-source match vectors against every entry.
module hz_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG_W = 3,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              issue,
  input  logic              wr,
  input  logic [NREG_W-1:0] rd,
  input  logic              load,
  input  logic              rs_vld,
  input  logic [NREG_W-1:0] rs,
  input  logic              rt_vld,
  input  logic [NREG_W-1:0] rt,
  output logic [DEPTH-1:0]  rs_match,
  output logic [DEPTH-1:0]  rt_match,
  output logic              load0,
  output logic              any_vld
);

  localparam int DAT_W  = sb_dat_w(NREG_W);
  localparam int WR_BIT = sb_wr_bit(NREG_W);
  localparam int RD_MSB = SB_RD_LSB + NREG_W - 1;

  logic [DEPTH-1:0] vld_p;
  logic [DAT_W-1:0] dat_p [DEPTH];
  logic [DAT_W-1:0] dat_in;

  assign dat_in = {wr, rd, load};

  // Valid bits are the only state that must be cleared; payload is don't-care when invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p <= {vld_p[DEPTH-2:0], issue};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      dat_p[0] <= dat_in;
      for (int i = 1; i < DEPTH; i++) begin
        dat_p[i] <= dat_p[i-1];
      end
    end
  end

  always_comb begin
    rs_match = '0;
    rt_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_match[i] = rs_vld & vld_p[i] & dat_p[i][WR_BIT] & (dat_p[i][RD_MSB:SB_RD_LSB] == rs);
      rt_match[i] = rt_vld & vld_p[i] & dat_p[i][WR_BIT] & (dat_p[i][RD_MSB:SB_RD_LSB] == rt);
    end
  end

  assign load0   = vld_p[0] & dat_p[0][SB_LOAD];
  assign any_vld = |vld_p;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/enable generation, forwarding selects,
// stall counter and HALT drain FSM. Define PIPE_FWD_EN for the forwarding build.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG_W      = 3,
  parameter int DEPTH       = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic                   dec_rs_vld,
  input  logic [NREG_W-1:0]      dec_rs,
  input  logic                   dec_rt_vld,
  input  logic [NREG_W-1:0]      dec_rt,
  input  logic                   dec_wr,
  input  logic [NREG_W-1:0]      dec_rd,
  input  logic                   dec_load,
  input  logic                   dec_halt,
  input  logic                   br_taken,
  input  logic                   dmem_stall,
  output logic                   fetch_en,
  output logic                   ifid_en,
  output logic                   ifid_flush,
  output logic                   idex_en,
  output logic                   idex_bubble,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  hz_state_e        state;
  logic [DEPTH-1:0] rs_match;
  logic [DEPTH-1:0] rt_match;
  logic             load0;
  logic             any_vld;
  logic             hz_raw;
  logic             hz;
  logic             issue;
  logic             unused_sb;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hz_scoreboard #(
    .NREG_W (NREG_W),
    .DEPTH  (DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .adv      (~dmem_stall),
    .issue    (issue),
    .wr       (dec_wr),
    .rd       (dec_rd),
    .load     (dec_load),
    .rs_vld   (dec_rs_vld),
    .rs       (dec_rs),
    .rt_vld   (dec_rt_vld),
    .rt       (dec_rt),
    .rs_match (rs_match),
    .rt_match (rt_match),
    .load0    (load0),
    .any_vld  (any_vld)
  );

  // Not every match bit is consumed in every build/depth combination.
  assign unused_sb = ^{rs_match, rt_match, load0};

`ifdef PIPE_FWD_EN
  assign hz_raw = load0 & (rs_match[0] | rt_match[0]);
`else
  // WB is exempt: the register file writes through to decode reads.
  assign hz_raw = |(rs_match[DEPTH-2:0] | rt_match[DEPTH-2:0]);
`endif

  assign hz    = (state == RUN) & dec_valid & hz_raw;
  assign issue = (state == RUN) & dec_valid & ~hz & ~dmem_stall;

  always_comb begin
    fetch_en    = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    if (dmem_stall) begin
      fetch_en = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      case (state)
        DRAIN: begin
          fetch_en    = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        HALTED: begin
          fetch_en    = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: begin
          if (hz) begin
            fetch_en    = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            ifid_flush = br_taken;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (!dmem_stall) begin
      case (state)
        RUN: begin
          if (issue && dec_halt) state <= DRAIN;
        end
        DRAIN: begin
          if (!any_vld) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!dmem_stall && hz) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

`ifdef PIPE_FWD_EN
  function automatic logic [1:0] fwd_pick(input logic m_ex, input logic m_mem);
    if (m_ex)  return FWD_EXMEM;
    if (m_mem) return FWD_MEMWB;
    return FWD_REG;
  endfunction

  // Selects register at issue so they line up with the consumer's EX cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
    end else if (!dmem_stall) begin
      if (issue) begin
        fwd_a <= fwd_pick(rs_match[0], rs_match[1]);
        fwd_b <= fwd_pick(rt_match[0], rt_match[1]);
      end else begin
        fwd_a <= FWD_REG;
        fwd_b <= FWD_REG;
      end
    end
  end
`else
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage processor: the next generation of the stall/forward logic now spread across the top level.
- Keeps a scoreboard of in-flight destination registers for EX, MEM and WB.
- Drives every pipeline-register enable, bubble and flush signal, registered forwarding selects, and a halt-drain state machine.
- Sits beside decode; all pipeline registers take their enables from it.

Parameters:
- NREG_W, 3, register-address width; the register file holds 2**NREG_W entries.
- DEPTH, 3, tracked post-decode stages (entry 0 = EX, 1 = MEM, DEPTH-1 = WB); legal range 3 to 5.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decode holds a real instruction
- dec_rs_vld  in  1  first source operand is used
- dec_rs  in  NREG_W  first source register
- dec_rt_vld  in  1  second source operand is used
- dec_rt  in  NREG_W  second source register
- dec_wr  in  1  instruction writes a register
- dec_rd  in  NREG_W  destination register
- dec_load  in  1  instruction is a load
- dec_halt  in  1  instruction is HALT
- br_taken  in  1  branch/jump resolved taken in decode
- dmem_stall  in  1  data memory busy
- fetch_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  load a NOP into IF/ID
- idex_en  out  1  ID/EX register enable
- idex_bubble  out  1  load a bubble into ID/EX
- exmem_en  out  1  EX/MEM enable
- memwb_en  out  1  MEM/WB enable
- fwd_a  out  2  EX operand-A select: 00 register file, 01 EX/MEM, 10 MEM/WB
- fwd_b  out  2  EX operand-B select, same encoding as fwd_a
- halted  out  1  pipeline drained after HALT
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset, synchronous and active-high: scoreboard cleared, FSM = RUN, fwd_a/fwd_b = 00, halted = 0, stall_cnt = 0. All enables are combinational from this state, so they read 1; ifid_flush and idex_bubble read 0.
- Scoreboard entries hold {vld, wr, rd, load}. They advance on every cycle with dmem_stall = 0:
  - entry 0 takes the decode instruction if it issues, otherwise a bubble (vld = 0).
  - entry i takes entry i-1.
- dmem_stall = 1 freezes everything: all enables 0, scoreboard, fwd regs and stall_cnt hold. It takes priority over every other condition.
- match(e, r) = e.vld & e.wr & (e.rd == r), checked for each source with its _vld bit set.
- Hazard stall (hz), forwarding build: some source matches entry 0 and entry 0 is a load.
- Hazard stall (hz), PIPE_FWD_EN absent: some source matches any entry 0..DEPTH-2. The WB entry is exempt because the register file writes through.
- On hz (and dmem_stall = 0):
  - fetch_en = ifid_en = 0.
  - idex_bubble = 1 with idex_en = 1.
  - the instruction does not issue.
  - stall_cnt increments and saturates at all-ones.
- Forwarding is computed on issue and registered, so it is valid during the consumer's EX cycle:
  - match(entry 0) gives 01.
  - else match(entry 1) gives 10.
  - else 00.
  - Entry 0 takes priority (youngest producer).
  - A bubble issue sets 00.
- br_taken with no hz sets ifid_flush = 1 for that edge. br_taken during hz is ignored, because decode re-evaluates next cycle.
- FSM RUN: dec_halt with the instruction issuing moves to DRAIN.
- FSM DRAIN:
  - fetch_en = 0, ifid_flush = 1, so no new instructions enter.
  - When all scoreboard entries are invalid, move to HALTED.
- FSM HALTED:
  - halted = 1, fetch_en = ifid_en = 0, idex_bubble = 1.
  - Only rst exits this state.
- rst mid-stall or mid-drain returns to the reset state on the next edge, with no residual bubbles.

Optional Feature:
- Macro PIPE_FWD_EN.
- Defined: forwarding build. Only load-use hazards stall, for 1 cycle; fwd_a/fwd_b are generated as above.
- Undefined: no forwarding. fwd_a/fwd_b are tied to 00, and the stall rule above lasts up to DEPTH-1 cycles per RAW dependency.

Decomposition:
- Shared package pipe_pkg holds:
  - the FWD_REG/FWD_EXMEM/FWD_MEMWB encodings;
  - the FSM state encodings RUN/DRAIN/HALTED;
  - the scoreboard entry field layout.
- One natural sub-module, hz_scoreboard: the DEPTH-entry shift register plus per-source match vectors. The top holds the FSM, enables, forwarding registers and the counter.

Test Plan:
- ADD r1 issued, next instruction reads r1, PIPE_FWD_EN on → no stall; fwd_a = 01 in the consumer's EX cycle. Insert one unrelated instruction between them → fwd_a = 10.
- LD r2 then ADD reads r2 (rt), PIPE_FWD_EN on → exactly one cycle of fetch_en = 0 with idex_bubble = 1, then fwd_b = 10; stall_cnt = 1.
- Same sequence with PIPE_FWD_EN off, DEPTH = 3 → 2 stall cycles, fwd_b = 00, stall_cnt = 2.
- dmem_stall held 4 cycles during a load-use stall → all enables 0 for those 4 cycles; stall_cnt unchanged; the remaining stall completes afterwards.
- br_taken with no hazard → ifid_flush = 1 for one cycle. br_taken during hz → ifid_flush = 0.
- HALT followed by 3 in-flight instructions → DRAIN until the scoreboard is empty, then halted = 1 within DEPTH cycles. Asserting rst afterwards gives halted = 0 and fetch_en = 1.
